led_pattern_seq: RTL and testbench

Parametrised LED pattern sequencer for the board LED bank, driven by the divided low-rate clock `clk1h`. It generalises the fixed 8-LED one-hot chase to N LEDs and four selectable patterns: walk, bounce, binary count and fill/drain. It also adds direction control, pause, configurable output polarity and a pattern-period marker. It sits between the clock divider and the LED pins.

---
 rtl/led_pattern_seq.sv | 216 +++++++++++++++++++++
 tb/tb_led_pattern_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: N-LED pattern sequencer stepped by the divided clock clk1h.
// Patterns: walk, bounce, binary count and fill/drain, with direction control,
// pause, configurable output polarity and a one-cycle pattern-period marker.
// Optional feature macro LEDSEQ_SPEED_EN: adds the speed input and a 3-bit
// prescaler so that a step is taken only on every 2^speed-th enabled edge.
module led_pattern_seq #(
    parameter int N          = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic         clk1h,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic         dir,
`ifdef LEDSEQ_SPEED_EN
    input  logic [1:0]   speed,
`endif
    output logic [N-1:0] led,
    output logic         wrap
);

    localparam int PW = $clog2(N);
    localparam int LW = $clog2(N + 1);

    localparam logic [PW-1:0] POS_LAST  = PW'(N - 1);
    localparam logic [PW-1:0] POS_PEN   = PW'(N - 2);
    localparam logic [LW-1:0] LEVEL_PEN = LW'(N - 1);
    localparam logic [N-1:0]  LED_OFF   = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
    localparam logic [N-1:0]  ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_WALK   = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_COUNT  = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    logic [PW-1:0] r_pos;
    logic          r_up;
    logic [N-1:0]  r_cnt;
    logic [LW-1:0] r_level;
    mode_t         r_modeQ;
    logic          r_started;
    logic [N-1:0]  r_led;
    logic          r_wrap;

    mode_t         w_mode;
    mode_t         w_patMode;
    logic          w_reinit;
    logic          w_step;
    logic [PW-1:0] w_nextPos;
    logic          w_nextUp;
    logic [N-1:0]  w_nextCnt;
    logic [LW-1:0] w_nextLevel;
    logic          w_nextWrap;
    logic [N-1:0]  w_fillMask;
    logic [N-1:0]  w_pattern;
    logic [N-1:0]  w_nextLed;

    assign w_mode   = mode_t'(mode);
    assign w_reinit = en && (!r_started || (w_mode != r_modeQ));

`ifdef LEDSEQ_SPEED_EN
    logic [2:0] r_pre;
    logic [1:0] r_speedQ;
    logic [2:0] w_preLast;
    logic       w_preTerminal;

    // Terminal prescaler count for the speed latched at the last terminal count
    always_comb begin
        w_preLast = 3'd0;
        case (r_speedQ)
            2'd0:    w_preLast = 3'd0;
            2'd1:    w_preLast = 3'd1;
            2'd2:    w_preLast = 3'd3;
            default: w_preLast = 3'd7;
        endcase
    end

    assign w_preTerminal = (r_pre == w_preLast);
    assign w_step        = en && !w_reinit && w_preTerminal;

    // Prescaler: restarts on reinit and terminal count, picks up a new speed there
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            r_pre    <= 3'd0;
            r_speedQ <= 2'd0;
        end else if (en) begin
            if (w_reinit || w_preTerminal) begin
                r_pre    <= 3'd0;
                r_speedQ <= speed;
            end else begin
                r_pre <= r_pre + 3'd1;
            end
        end
    end
`else
    assign w_step = en && !w_reinit;
`endif

    // Next sequencer state: load the mode's initial state on reinit, else one step
    always_comb begin
        w_nextPos   = r_pos;
        w_nextUp    = r_up;
        w_nextCnt   = r_cnt;
        w_nextLevel = r_level;
        w_nextWrap  = 1'b0;
        if (w_reinit) begin
            w_nextPos   = ((w_mode == MODE_WALK) && dir) ? POS_LAST : '0;
            w_nextUp    = 1'b1;
            w_nextCnt   = '0;
            w_nextLevel = '0;
        end else if (w_step) begin
            case (r_modeQ)
                MODE_WALK: begin
                    if (dir) begin
                        w_nextPos  = (r_pos == '0) ? POS_LAST : r_pos - PW'(1);
                        w_nextWrap = (r_pos == '0);
                    end else begin
                        w_nextPos  = (r_pos == POS_LAST) ? '0 : r_pos + PW'(1);
                        w_nextWrap = (r_pos == POS_LAST);
                    end
                end
                MODE_BOUNCE: begin
                    if (r_up) begin
                        w_nextPos = r_pos + PW'(1);
                        if (r_pos == POS_PEN) begin
                            w_nextUp = 1'b0;
                        end
                    end else begin
                        w_nextPos = r_pos - PW'(1);
                        if (r_pos == PW'(1)) begin
                            w_nextUp   = 1'b1;
                            w_nextWrap = 1'b1;
                        end
                    end
                end
                MODE_COUNT: begin
                    if (dir) begin
                        w_nextCnt  = r_cnt - N'(1);
                        w_nextWrap = (r_cnt == N'(1));
                    end else begin
                        w_nextCnt  = r_cnt + N'(1);
                        w_nextWrap = (r_cnt == {N{1'b1}});
                    end
                end
                default: begin
                    if (r_up) begin
                        w_nextLevel = r_level + LW'(1);
                        if (r_level == LEVEL_PEN) begin
                            w_nextUp = 1'b0;
                        end
                    end else begin
                        w_nextLevel = r_level - LW'(1);
                        if (r_level == LW'(1)) begin
                            w_nextUp   = 1'b1;
                            w_nextWrap = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Logical pattern for the state being loaded, then output polarity
    always_comb begin
        w_patMode = w_reinit ? w_mode : r_modeQ;
        for (int i = 0; i < N; i++) begin
            w_fillMask[i] = (LW'(i) < w_nextLevel);
        end
        w_pattern = '0;
        case (w_patMode)
            MODE_WALK, MODE_BOUNCE: w_pattern = ONE_HOT0 << w_nextPos;
            MODE_COUNT:             w_pattern = w_nextCnt;
            default: begin
                for (int i = 0; i < N; i++) begin
                    w_pattern[i] = dir ? w_fillMask[N-1-i] : w_fillMask[i];
                end
            end
        endcase
        w_nextLed = (ACTIVE_LOW != 0) ? ~w_pattern : w_pattern;
    end

    // State and output registers; everything holds while paused, wrap drops
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            r_pos     <= '0;
            r_up      <= 1'b1;
            r_cnt     <= '0;
            r_level   <= '0;
            r_modeQ   <= MODE_WALK;
            r_started <= 1'b0;
            r_led     <= LED_OFF;
            r_wrap    <= 1'b0;
        end else if (en) begin
            r_pos   <= w_nextPos;
            r_up    <= w_nextUp;
            r_cnt   <= w_nextCnt;
            r_level <= w_nextLevel;
            r_wrap  <= w_nextWrap;
            if (w_reinit) begin
                r_modeQ   <= w_mode;
                r_started <= 1'b1;
            end
            if (w_reinit || w_step) begin
                r_led <= w_nextLed;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign led  = r_led;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Testbench for led_pattern_seq: two instances (8 LEDs active-low, 5 LEDs
// active-high) share stimulus; expected outputs come from a phase-based model
// and are queued per edge, a monitor pops and compares after each event.
`timescale 1ns/1ps
module tb_led_pattern_seq;

    localparam int NA  = 8;
    localparam int ALA = 1;
    localparam int NB  = 5;
    localparam int ALB = 0;

    logic          clk1h = 1'b0;
    logic          rst   = 1'b1;
    logic          en    = 1'b0;
    logic [1:0]    mode  = 2'b00;
    logic          dir   = 1'b0;
    logic [1:0]    speed = 2'b00;
    logic [NA-1:0] ledA;
    logic          wrapA;
    logic [NB-1:0] ledB;
    logic          wrapB;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NA-1:0] ledA;
        logic          wrapA;
        logic [NB-1:0] ledB;
        logic          wrapB;
    } expect_t;

    expect_t sbQueue[$];

    int mStarted[2];
    int mMode[2];
    int mPos[2];
    int mPhase[2];
    int mCnt[2];
    int mPre[2];
    int mSpeedQ[2];
    int mP[2];
    int mWrap[2];

    led_pattern_seq #(.N(NA), .ACTIVE_LOW(ALA)) dutA (
        .clk1h(clk1h),
        .rst(rst),
        .en(en),
        .mode(mode),
        .dir(dir),
`ifdef LEDSEQ_SPEED_EN
        .speed(speed),
`endif
        .led(ledA),
        .wrap(wrapA)
    );

    led_pattern_seq #(.N(NB), .ACTIVE_LOW(ALB)) dutB (
        .clk1h(clk1h),
        .rst(rst),
        .en(en),
        .mode(mode),
        .dir(dir),
`ifdef LEDSEQ_SPEED_EN
        .speed(speed),
`endif
        .led(ledB),
        .wrap(wrapB)
    );

    always #5 clk1h = ~clk1h;

    function automatic int nOf(int i);
        return (i == 0) ? NA : NB;
    endfunction

    // Logical pattern derived from the position within the pattern period
    function automatic int patternOf(int i, int d);
        int n;
        int bpos;
        int lvl;
        int full;
        n = nOf(i);
        case (mMode[i])
            0: return 1 << mPos[i];
            1: begin
                bpos = (mPhase[i] < n) ? mPhase[i] : (2 * n - 2 - mPhase[i]);
                return 1 << bpos;
            end
            2: return mCnt[i];
            default: begin
                lvl  = (mPhase[i] <= n) ? mPhase[i] : (2 * n - mPhase[i]);
                full = (1 << lvl) - 1;
                return (d != 0) ? (full << (n - lvl)) : full;
            end
        endcase
    endfunction

    function automatic int expLed(int i);
        int n;
        int al;
        int v;
        n  = nOf(i);
        al = (i == 0) ? ALA : ALB;
        v  = (al != 0) ? ~mP[i] : mP[i];
        return v & ((1 << n) - 1);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mStarted[i] = 0;
            mMode[i]    = 0;
            mPos[i]     = 0;
            mPhase[i]   = 0;
            mCnt[i]     = 0;
            mPre[i]     = 0;
            mSpeedQ[i]  = 0;
            mP[i]       = 0;
            mWrap[i]    = 0;
        end
    endtask

    task automatic modelEdge(input int i, input int e, input int m, input int d, input int s);
        int n;
        int doStep;
        n = nOf(i);
        mWrap[i] = 0;
        if (e == 0) return;
        if (mStarted[i] == 0 || m != mMode[i]) begin
            mStarted[i] = 1;
            mMode[i]    = m;
            mPos[i]     = (m == 0 && d != 0) ? n - 1 : 0;
            mPhase[i]   = 0;
            mCnt[i]     = 0;
            mPre[i]     = 0;
            mSpeedQ[i]  = s;
            mP[i]       = patternOf(i, d);
            return;
        end
`ifdef LEDSEQ_SPEED_EN
        mPre[i] = mPre[i] + 1;
        if (mPre[i] == (1 << mSpeedQ[i])) begin
            doStep     = 1;
            mPre[i]    = 0;
            mSpeedQ[i] = s;
        end else begin
            doStep = 0;
        end
`else
        doStep = 1;
`endif
        if (doStep == 0) return;
        case (mMode[i])
            0: begin
                mPos[i]  = (mPos[i] + ((d != 0) ? n - 1 : 1)) % n;
                mWrap[i] = (mPos[i] == ((d != 0) ? n - 1 : 0)) ? 1 : 0;
            end
            1: begin
                mPhase[i] = (mPhase[i] + 1) % (2 * n - 2);
                mWrap[i]  = (mPhase[i] == 0) ? 1 : 0;
            end
            2: begin
                mCnt[i]  = (mCnt[i] + ((d != 0) ? (1 << n) - 1 : 1)) % (1 << n);
                mWrap[i] = (mCnt[i] == 0) ? 1 : 0;
            end
            default: begin
                mPhase[i] = (mPhase[i] + 1) % (2 * n);
                mWrap[i]  = (mPhase[i] == 0) ? 1 : 0;
            end
        endcase
        mP[i] = patternOf(i, d);
    endtask

    task automatic pushExpected();
        expect_t e;
        e.ledA  = NA'(expLed(0));
        e.wrapA = (mWrap[0] != 0);
        e.ledB  = NB'(expLed(1));
        e.wrapB = (mWrap[1] != 0);
        sbQueue.push_back(e);
    endtask

    // Drive one clk1h period of inputs; a falling rst also queues an immediate check
    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                                 input logic d, input logic [1:0] s);
        if (!r && rst) begin
            modelReset();
            pushExpected();
            rst = 1'b0;
        end
        rst   = r;
        en    = e;
        mode  = m;
        dir   = d;
        speed = s;
        if (!r) begin
            modelReset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                modelEdge(i, int'(e), int'(m), int'(d), int'(s));
            end
        end
        pushExpected();
        @(negedge clk1h);
    endtask

    task automatic checkOutput(input string name, input int sample,
                               input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s sample %0d: got %0h, required %0h", name, sample, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per rising clock edge or reset assertion
    initial begin
        expect_t e;
        int sample;
        sample = 0;
        forever begin
            @(posedge clk1h or negedge rst);
            #1;
            sample++;
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard sample %0d: got no expected entry, required one", sample);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("ledA", sample, 32'(ledA), 32'(e.ledA));
                checkOutput("wrapA", sample, 32'(wrapA), 32'(e.wrapA));
                checkOutput("ledB", sample, 32'(ledB), 32'(e.ledB));
                checkOutput("wrapB", sample, 32'(wrapB), 32'(e.wrapB));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of stimulus, required one by 100000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequences from the pattern descriptions, then randomized traffic
    initial begin
        logic [1:0] curMode;
        logic       curDir;
        logic [1:0] curSpeed;
        logic       curEn;
        logic       curRst;

        modelReset();
        #1;
        $display("[TB] reset");
        repeat (3) applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 2'd0);

        $display("[TB] walk forward then reversed");
        repeat (10) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 2'd0);
        repeat (4)  applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 2'd0);

        $display("[TB] bounce");
        repeat (16) applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 2'd0);

        $display("[TB] count down with pause");
        repeat (4) applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 2'd0);
        repeat (3) applyStimulus(1'b1, 1'b0, 2'b10, 1'b1, 2'd0);
        repeat (3) applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 2'd0);

        $display("[TB] fill from MSB");
        repeat (18) applyStimulus(1'b1, 1'b1, 2'b11, 1'b1, 2'd0);

        $display("[TB] mode change walk to count");
        repeat (3) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 2'd0);
        repeat (2) applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 2'd0);

        $display("[TB] reset mid-pattern");
        repeat (4) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 2'd0);
        repeat (2) applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 2'd0);
        repeat (3) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 2'd0);

        $display("[TB] count with speed 2");
        repeat (13) applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 2'd2);

        $display("[TB] randomized");
        curMode  = 2'b00;
        curDir   = 1'b0;
        curSpeed = 2'd0;
        for (int k = 0; k < 600; k++) begin
            curRst = ($urandom_range(0, 99) != 0);
            curEn  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 5)  curMode  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 8)  curDir   = ~curDir;
            if ($urandom_range(0, 99) < 5)  curSpeed = 2'($urandom_range(0, 3));
            applyStimulus(curRst, curEn, curMode, curDir, curSpeed);
        end

        #2;
        checks++;
        if (sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending entries, required 0", sbQueue.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
